alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue stage directly upstream of alu. Accepts decoded instruction fields over valid/ready,
//  selects operand 2 (register or immediate), derives 4-bit alu_c from alu_op/funct fields,
//  and holds in1/in2/alu_c in a 2-entry skid buffer presented to the ALU.
//  Backpressure from EX never loses or reorders an accepted operation.
// PARAMETERS
//  XLEN     64  operand width; matches ALU in1/in2/result width
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous reset, active-low
//  s_valid    in   1     decode presents an operation
//  s_ready    out  1     stage can accept this cycle
//  rs1_data   in   XLEN  register operand 1
//  rs2_data   in   XLEN  register operand 2
//  imm        in   XLEN  sign-extended immediate
//  alu_src    in   1     1 = in2 takes imm, 0 = in2 takes rs2_data
//  alu_op     in   2     00 mem, 01 branch, 10 R/I arithmetic, 11 reserved
//  funct3     in   3     instruction funct3
//  funct7_30  in   1     instruction bit 30
//  m_valid    out  1     in1/in2/alu_c valid toward ALU
//  m_ready    in   1     EX consumes this cycle
//  in1        out  XLEN  ALU operand 1
//  in2        out  XLEN  ALU operand 2
//  alu_c      out  4     ALU control code
//  op_err     out  1     (ALU_OP_CHECK_EN only) current head entry had illegal encoding
// BEHAVIOUR
//  - Reset (async, rst_n=0): count=0, m_valid=0, in1=0, in2=0, alu_c=0, op_err=0; s_ready=1 once count=0.
//  - Transfer in: s_valid&s_ready at rising edge. Transfer out: m_valid&m_ready at rising edge.
//  - Decode at entry (registered after decode), codes: AND=0000 OR=0001 ADD=0010 SUB=0110.
//    alu_op 00 -> ADD; 01 -> SUB; 10: funct3 000 -> SUB if funct7_30 & !alu_src else ADD;
//    111 -> AND; 110 -> OR; other funct3 -> illegal; alu_op 11 -> illegal. Illegal -> ADD.
//  - in1 = rs1_data; in2 = alu_src ? imm : rs2_data, sampled at transfer-in.
//  - Buffer: 2 entries, FIFO order, count 0..2. s_ready = (count<2), registered, no comb path
//    from m_ready. m_valid = (count>0). Outputs always show head entry; head stable while
//    m_valid & !m_ready.
//  - Latency: accept at edge N -> m_valid with that op after edge N (empty buffer). 1 op/cycle
//    sustained when m_ready held high.
//  - Simultaneous in+out: count unchanged; at count=2, s_ready=0 so only out occurs -> count=1.
//  - count=1, out only: m_valid falls; in1/in2/alu_c hold last value (no clear).
//  - Reset mid-operation: all entries discarded immediately, outputs per reset list.
//  - Read/write pointers are 1 bit, wrap 1->0.
// CONFIGURATION
//  ALU_OP_CHECK_EN defined: each entry stores 1-bit err; op_err = m_valid & head.err;
//    illegal ops still issue as ADD.
//  Not defined: op_err port absent, no err storage; illegal ops silently issue as ADD.
// STRUCTURE
//  - Shared header alu_defs.vh: `define ALU_AND/ALU_OR/ALU_ADD/ALU_SUB codes, ALUOP_MEM/BR/ARITH
//    codes; also included by alu.
//  - Sub-module alu_ctrl_dec (combinational): alu_op, funct3, funct7_30, alu_src -> alu_c, illegal.
//  - Top: 2-entry storage, pointers, count, in2 mux.
// TESTING
//  1 reset: rst_n=0 with s_valid=1 -> m_valid=0, in1=in2=0, alu_c=0, s_ready=1 after release.
//  2 R-type SUB: rs1=6, rs2=23, alu_op=10, f3=000, f7_30=1, alu_src=0, m_ready=1
//    -> next cycle in1=6, in2=23, alu_c=0110, m_valid=1.
//  3 I-type ADDI: rs1=6, imm=-8, alu_src=1, f7_30=1 -> in2=64'hFFFF_FFFF_FFFF_FFF8, alu_c=0010.
//  4 backpressure: m_ready=0, push AND, OR, third op -> s_ready=0 after 2 accepts;
//    raise m_ready -> AND then OR then third op, no loss.
//  5 streaming: s_valid=m_ready=1 for 10 cycles, ops AND/OR/ADD cycling -> 10 issues,
//    count never 2.
//  6 illegal alu_op=11 (CHECK_EN on) -> alu_c=0010, op_err=1 while head;
//    reset asserted with count=2 -> m_valid=0 asynchronously.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ID/EX issue stage: ALU control codes, alu_op
// classes and the default operand width. Also meant to be imported by the ALU.
package alu_issue_stage_pkg;

  localparam int XLEN_DEFAULT = 64;

  // 4-bit ALU control codes understood by the downstream ALU
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_ctrl_e;

  // Instruction class coming from the main decoder
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_ARITH = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_issue_stage_ctrl_dec.sv
// alu_ctrl_dec: combinational translation of alu_op / funct fields into the
// 4-bit ALU control code. Encodings with no defined meaning are flagged as
// illegal and fall back to ADD so the pipeline still issues something benign.
module alu_ctrl_dec
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_30,
  input  logic       alu_src,
  output logic [3:0] alu_c,
  output logic       illegal
);

  // Map instruction class and funct fields onto an ALU operation
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    alu_c   = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_c = ALU_ADD;
      ALUOP_BR:  alu_c = ALU_SUB;
      ALUOP_ARITH: begin
        case (funct3)
          // Immediate forms never subtract: bit 30 is part of the immediate there
          F3_ADD_SUB: alu_c = (funct7_30 && !alu_src) ? ALU_SUB : ALU_ADD;
          F3_AND:     alu_c = ALU_AND;
          F3_OR:      alu_c = ALU_OR;
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage in front of the ALU. Decodes alu_c,
// selects operand 2 and queues {in1, in2, alu_c} in a 2-entry FIFO skid
// buffer so EX backpressure never drops or reorders an accepted operation.
// s_ready is registered, so there is no combinational path from m_ready.
// Optional build macro ALU_OP_CHECK_EN: store an illegal-encoding flag per
// entry and expose it on op_err for the head entry.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_30,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
`ifdef ALU_OP_CHECK_EN
  output logic [3:0]      alu_c,
  output logic            op_err
`else
  output logic [3:0]      alu_c
`endif
);

  logic [XLEN-1:0] r_in1_mem   [2];
  logic [XLEN-1:0] r_in2_mem   [2];
  logic [3:0]      r_alu_c_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic            r_s_ready;

  logic [3:0]      w_alu_c;
  logic            w_illegal;
  logic [XLEN-1:0] w_in2_sel;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count_nxt;
  logic            w_out_idx;

  alu_ctrl_dec u_ctrl_dec (
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_30 (funct7_30),
    .alu_src   (alu_src),
    .alu_c     (w_alu_c),
    .illegal   (w_illegal)
  );

  assign w_in2_sel = alu_src ? imm : rs2_data;
  assign w_push    = s_valid & r_s_ready;
  assign w_pop     = m_valid & m_ready;
  assign m_valid   = (r_count != 2'd0);
  assign s_ready   = r_s_ready;

  // When empty, point at the entry just popped so the outputs hold their last value
  assign w_out_idx = m_valid ? r_rd_ptr : ~r_rd_ptr;
  assign in1       = r_in1_mem[w_out_idx];
  assign in2       = r_in2_mem[w_out_idx];
  assign alu_c     = r_alu_c_mem[w_out_idx];

  // Occupancy after this cycle's transfers; simultaneous in+out leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // Pointers, occupancy and the registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_s_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count   <= w_count_nxt;
      r_s_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Entry storage, written at the tail on every accepted operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because the outputs read it directly and must show zero after reset.
      for (int i = 0; i < 2; i++) begin
        r_in1_mem[i]   <= '0;
        r_in2_mem[i]   <= '0;
        r_alu_c_mem[i] <= 4'b0000;
      end
    end else if (w_push) begin
      r_in1_mem[r_wr_ptr]   <= rs1_data;
      r_in2_mem[r_wr_ptr]   <= w_in2_sel;
      r_alu_c_mem[r_wr_ptr] <= w_alu_c;
    end
  end

`ifdef ALU_OP_CHECK_EN
  logic r_err_mem [2];

  // Per-entry illegal-encoding flag travelling alongside the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_mem[0] <= 1'b0;
      r_err_mem[1] <= 1'b0;
    end else if (w_push) begin
      r_err_mem[r_wr_ptr] <= w_illegal;
    end
  end

  assign op_err = m_valid & r_err_mem[r_rd_ptr];
`else
  // Illegal encodings still issue as ADD; the flag itself has no consumer here
  logic w_illegal_unused;
  assign w_illegal_unused = w_illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: reset, directed decode table,
// directed backpressure/streaming/reset sequences and randomized traffic
// compared against a queue-based reference model.
// Build with +define+ALU_OP_CHECK_EN to also exercise op_err.
module tb_alu_issue_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            alu_src;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7_30;
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] in1, in2;
  logic [3:0]      alu_c;
  logic            op_err;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_30 (funct7_30),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .in1       (in1),
    .in2       (in2),
`ifdef ALU_OP_CHECK_EN
    .alu_c     (alu_c),
    .op_err    (op_err)
`else
    .alu_c     (alu_c)
`endif
  );

`ifndef ALU_OP_CHECK_EN
  assign op_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int dut_issued = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  c;
    logic        e;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   m_s_ready;

  // ALU code and illegal flag straight from the instruction-class rules
  function automatic exp_t ref_op(input logic [63:0] r1, input logic [63:0] r2,
                                  input logic [63:0] im, input logic src,
                                  input logic [1:0] op, input logic [2:0] f3, input logic f7);
    exp_t r;
    r.a = r1;
    r.b = src ? im : r2;
    r.c = 4'd2;   // ADD unless a rule says otherwise
    r.e = 1'b0;
    if (op == 2'd1) r.c = 4'd6;
    else if (op == 2'd2) begin
      if (f3 == 3'd0 && f7 && !src) r.c = 4'd6;
      else if (f3 == 3'd7) r.c = 4'd0;
      else if (f3 == 3'd6) r.c = 4'd1;
      else if (f3 != 3'd0) r.e = 1'b1;
    end else if (op == 2'd3) r.e = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    last = '{a: 64'd0, b: 64'd0, c: 4'd0, e: 1'b0};
    m_s_ready = 1'b1;
  endtask

  task automatic compare_outputs();
    exp_t h;
    h = (q.size() > 0) ? q[0] : last;
    check("m_valid", 64'(m_valid), 64'(q.size() > 0));
    check("s_ready", 64'(s_ready), 64'(m_s_ready));
    check("in1",     in1, h.a);
    check("in2",     in2, h.b);
    check("alu_c",   64'(alu_c), 64'(h.c));
`ifdef ALU_OP_CHECK_EN
    check("op_err",  64'(op_err), 64'((q.size() > 0) && h.e));
`endif
  endtask

  // One clock: inputs already driven, model follows the handshake rules
  task automatic step();
    bit   push, pop;
    exp_t ent;
    push = s_valid && m_s_ready;
    pop  = (q.size() > 0) && m_ready;
    ent  = ref_op(rs1_data, rs2_data, imm, alu_src, alu_op, funct3, funct7_30);
    if (m_valid && m_ready) dut_issued++;
    @(posedge clk);
    if (pop)  last = q.pop_front();
    if (push) q.push_back(ent);
    m_s_ready = (q.size() < 2);
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic v, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] im, input logic src, input logic [1:0] op,
                       input logic [2:0] f3, input logic f7);
    s_valid = v; rs1_data = r1; rs2_data = r2; imm = im;
    alu_src = src; alu_op = op; funct3 = f3; funct7_30 = f7;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       src;
    logic [3:0] exp_c;
    logic       exp_ill;
  } dec_vec_t;

  dec_vec_t vecs[12];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int start_issued;
    bit saw_full;

    vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[1]  = '{2'b00, 3'b010, 1'b1, 1'b1, 4'b0010, 1'b0};
    vecs[2]  = '{2'b01, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0};
    vecs[3]  = '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0};
    vecs[4]  = '{2'b10, 3'b000, 1'b1, 1'b1, 4'b0010, 1'b0};
    vecs[5]  = '{2'b10, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[6]  = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[7]  = '{2'b10, 3'b110, 1'b1, 1'b0, 4'b0001, 1'b0};
    vecs[8]  = '{2'b10, 3'b001, 1'b0, 1'b0, 4'b0010, 1'b1};
    vecs[9]  = '{2'b10, 3'b100, 1'b0, 1'b1, 4'b0010, 1'b1};
    vecs[10] = '{2'b11, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b1};
    vecs[11] = '{2'b11, 3'b111, 1'b1, 1'b1, 4'b0010, 1'b1};

    // 1: reset with s_valid high
    rst_n = 1'b0;
    m_ready = 1'b0;
    drive(1'b1, 64'd5, 64'd7, 64'd9, 1'b0, 2'b10, 3'b111, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst m_valid", 64'(m_valid), 64'd0);
    check("rst in1", in1, 64'd0);
    check("rst in2", in2, 64'd0);
    check("rst alu_c", 64'(alu_c), 64'd0);
    check("rst op_err", 64'(op_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;
    #1;
    check("rst s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // 2: R-type SUB
    m_ready = 1'b1;
    drive(1'b1, 64'd6, 64'd23, 64'd0, 1'b0, 2'b10, 3'b000, 1'b1);
    step();
    check("sub in1", in1, 64'd6);
    check("sub in2", in2, 64'd23);
    check("sub alu_c", 64'(alu_c), 64'b0110);
    check("sub m_valid", 64'(m_valid), 64'd1);

    // 3: ADDI with negative immediate
    drive(1'b1, 64'd6, 64'd23, -64'sd8, 1'b1, 2'b10, 3'b000, 1'b1);
    step();
    check("addi in2", in2, 64'hFFFF_FFFF_FFFF_FFF8);
    check("addi alu_c", 64'(alu_c), 64'b0010);

    // Decode table, one op per cycle with EX always ready
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 64'(i), 64'(100 + i), 64'(200 + i), vecs[i].src, vecs[i].op, vecs[i].f3, vecs[i].f7);
      step();
      check($sformatf("vec%0d alu_c", i), 64'(alu_c), 64'(vecs[i].exp_c));
      check($sformatf("vec%0d in2", i), in2, vecs[i].src ? 64'(200 + i) : 64'(100 + i));
`ifdef ALU_OP_CHECK_EN
      check($sformatf("vec%0d op_err", i), 64'(op_err), 64'(vecs[i].exp_ill));
`endif
    end
    s_valid = 1'b0;
    step();
    check("drain m_valid", 64'(m_valid), 64'd0);
    check("hold in1", in1, 64'd11);
    check("hold alu_c", 64'(alu_c), 64'b0010);

    // 4: backpressure, AND / OR / ADD with EX stalled
    m_ready = 1'b0;
    drive(1'b1, 64'd11, 64'd1, 64'd0, 1'b0, 2'b10, 3'b111, 1'b0);
    step();
    drive(1'b1, 64'd22, 64'd2, 64'd0, 1'b0, 2'b10, 3'b110, 1'b0);
    step();
    check("bp full s_ready", 64'(s_ready), 64'd0);
    drive(1'b1, 64'd33, 64'd3, 64'd0, 1'b0, 2'b00, 3'b000, 1'b0);
    step();
    check("bp stall head in1", in1, 64'd11);
    check("bp stall head alu_c", 64'(alu_c), 64'b0000);
    m_ready = 1'b1;
    step();
    check("bp 2nd in1", in1, 64'd22);
    check("bp 2nd alu_c", 64'(alu_c), 64'b0001);
    step();
    check("bp 3rd in1", in1, 64'd33);
    check("bp 3rd alu_c", 64'(alu_c), 64'b0010);
    s_valid = 1'b0;
    step();
    check("bp empty m_valid", 64'(m_valid), 64'd0);

    // 5: streaming, 10 ops with both sides always ready
    start_issued = dut_issued;
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0: drive(1'b1, 64'(40 + i), 64'(i), 64'd0, 1'b0, 2'b10, 3'b111, 1'b0);
        1: drive(1'b1, 64'(40 + i), 64'(i), 64'd0, 1'b0, 2'b10, 3'b110, 1'b0);
        default: drive(1'b1, 64'(40 + i), 64'(i), 64'd0, 1'b0, 2'b00, 3'b000, 1'b0);
      endcase
      step();
      if (!s_ready) saw_full = 1'b1;
    end
    s_valid = 1'b0;
    step();
    check("stream issued", 64'(dut_issued - start_issued), 64'd10);
    check("stream never full", 64'(saw_full), 64'd0);

    // 6: illegal op at head, then asynchronous reset with a full buffer
    m_ready = 1'b0;
    drive(1'b1, 64'd77, 64'd7, 64'd0, 1'b0, 2'b11, 3'b000, 1'b0);
    step();
    check("illegal alu_c", 64'(alu_c), 64'b0010);
`ifdef ALU_OP_CHECK_EN
    check("illegal op_err", 64'(op_err), 64'd1);
`endif
    drive(1'b1, 64'd88, 64'd8, 64'd0, 1'b0, 2'b10, 3'b111, 1'b0);
    step();
    check("pre-reset full", 64'(s_ready), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst m_valid", 64'(m_valid), 64'd0);
    check("async rst in1", in1, 64'd0);
    check("async rst alu_c", 64'(alu_c), 64'd0);
    check("async rst op_err", 64'(op_err), 64'd0);
    model_reset();
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    compare_outputs();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
      m_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
